// File: rtl/kernel_collatz.sv
// kernel_collatz: per-thread Collatz step counter; iterates n until it reaches 1 and reports the step count.
// Ports: clk, srst (sync active-high), in_data[15:0] operand, in_valid level job request,
//        out_data[15:0] step count or 16'hFFFF on overflow/limit, out_valid level result flag, busy (in RUN).
// Optional macro COLLATZ_SHORTCUT_EN: odd steps fold the following halving into the same cycle.
module kernel_collatz #(
    parameter int WIDTH     = 32,
    parameter int MAX_STEPS = 1000
) (
    input  logic        clk,
    input  logic        srst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE = 3'b001, RUN = 3'b010, DONE = 3'b100} state_t;
    localparam logic [WIDTH-1:0] N_ONE = 1;
    localparam logic [WIDTH+1:0] T_ONE = 1;
    localparam logic [15:0] MAX16 = 16'(MAX_STEPS);
    state_t           r_state;
    logic [WIDTH-1:0] r_n;
    logic [15:0]      r_steps;
    logic [15:0]      r_out_data;
    logic             r_out_valid;
    logic             r_busy;
    logic [WIDTH+1:0] w_tri;
    logic             w_ovf;
    logic [WIDTH-1:0] w_odd_n;
    logic [15:0]      w_odd_inc;
    // 3n+1 in two extra bits so a too-large result is visible in the top bits
    assign w_tri = ({2'b00, r_n} << 1) + {2'b00, r_n} + T_ONE;
    assign w_ovf = |w_tri[WIDTH+1:WIDTH];
`ifdef COLLATZ_SHORTCUT_EN
    // 3n+1 is always even, so its halving is folded in and counted as a second step
    assign w_odd_n   = w_tri[WIDTH:1];
    assign w_odd_inc = 16'd2;
`else
    assign w_odd_n   = w_tri[WIDTH-1:0];
    assign w_odd_inc = 16'd1;
`endif
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state     <= IDLE;
            r_n         <= '0;
            r_steps     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_out_valid <= 1'b0;
                    if (in_valid) begin
                        r_n     <= WIDTH'(in_data);
                        r_steps <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!in_valid) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_n <= N_ONE) begin
                        r_out_data  <= r_steps;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= DONE;
                    end else if (r_steps >= MAX16 || (r_n[0] && w_ovf)) begin
                        r_out_data  <= 16'hFFFF;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= DONE;
                    end else if (!r_n[0]) begin
                        r_n     <= r_n >> 1;
                        r_steps <= r_steps + 16'd1;
                    end else begin
                        r_n     <= w_odd_n;
                        r_steps <= r_steps + w_odd_inc;
                    end
                end
                DONE: begin
                    if (!in_valid) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_kernel_collatz.sv
// tb_kernel_collatz: randomized self-checking bench for kernel_collatz against an arithmetic reference model.
module tb_kernel_collatz;
    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [15:0] od [3];
    logic        ov [3];
    logic        bz [3];
    int checks = 0;
    int errors = 0;
    int p_w [3] = '{32, 32, 16};
    int p_m [3] = '{1000, 100, 1000};
    int got_lat [3];
    logic [15:0] got_data [3];
`ifdef COLLATZ_SHORTCUT_EN
    bit sc = 1'b1;
`else
    bit sc = 1'b0;
`endif

    always #5 clk = ~clk;

    kernel_collatz #(.WIDTH(32), .MAX_STEPS(1000)) u_def (
        .clk(clk), .srst(srst), .in_data(in_data), .in_valid(in_valid),
        .out_data(od[0]), .out_valid(ov[0]), .busy(bz[0]));
    kernel_collatz #(.WIDTH(32), .MAX_STEPS(100)) u_m100 (
        .clk(clk), .srst(srst), .in_data(in_data), .in_valid(in_valid),
        .out_data(od[1]), .out_valid(ov[1]), .busy(bz[1]));
    kernel_collatz #(.WIDTH(16), .MAX_STEPS(1000)) u_w16 (
        .clk(clk), .srst(srst), .in_data(in_data), .in_valid(in_valid),
        .out_data(od[2]), .out_valid(ov[2]), .busy(bz[2]));

    // Reference: result and the edge (counted from capture) at which the result appears
    function automatic void model(input int n0, input int width, input int maxs,
                                  output int res, output int lat);
        longint n = n0;
        longint lim = longint'(1) << width;
        int s = 0;
        lat = 1;
        forever begin
            if (n <= 1) begin res = s; return; end
            if (s >= maxs) begin res = 16'hFFFF; return; end
            if (n % 2 == 0) begin
                n = n / 2;
                s = s + 1;
            end else begin
                if (3 * n + 1 >= lim) begin res = 16'hFFFF; return; end
                n = sc ? (3 * n + 1) / 2 : 3 * n + 1;
                s = s + (sc ? 2 : 1);
            end
            lat = lat + 1;
        end
    endfunction

    task automatic check_idle(input string name);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ov[d] !== 1'b0 || bz[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s dut%0d: out_valid=%b busy=%b, required 0 0", name, d, ov[d], bz[d]);
            end
        end
    endtask

    task automatic check_reset_vals(input string name);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ov[d] !== 1'b0 || bz[d] !== 1'b0 || od[d] !== 16'h0000) begin
                errors++;
                $display("FAIL %s dut%0d: out_valid=%b busy=%b out_data=%h, required 0 0 0000",
                         name, d, ov[d], bz[d], od[d]);
            end
        end
    endtask

    // Starts a job, tracks each DUT until it signals completion, leaves them in DONE
    task automatic run_job(input logic [15:0] n0);
        int er [3];
        int el [3];
        bit seen [3];
        for (int d = 0; d < 3; d++) begin
            model(int'(n0), p_w[d], p_m[d], er[d], el[d]);
            seen[d] = 1'b0;
            got_lat[d] = 0;
            got_data[d] = 16'h0;
        end
        @(negedge clk);
        in_data = n0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (bz[d] !== 1'b1 || ov[d] !== 1'b0) begin
                errors++;
                $display("FAIL job_start n0=%0d dut%0d: busy=%b out_valid=%b, required 1 0", n0, d, bz[d], ov[d]);
            end
        end
        in_data = 16'($urandom_range(0, 65535));
        for (int e = 1; e <= 1100 && !(seen[0] && seen[1] && seen[2]); e++) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (ov[d] === 1'b1 && !seen[d]) begin
                    seen[d] = 1'b1;
                    got_lat[d] = e;
                    got_data[d] = od[d];
                end
                checks++;
                if (bz[d] !== !seen[d]) begin
                    errors++;
                    $display("FAIL busy n0=%0d dut%0d edge %0d: busy=%b, required %b", n0, d, e, bz[d], !seen[d]);
                end
            end
            in_data = 16'($urandom_range(0, 65535));
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (got_data[d] !== 16'(er[d]) || got_lat[d] != el[d]) begin
                errors++;
                $display("FAIL result n0=%0d dut%0d: out_data=%h latency=%0d, required %h latency=%0d",
                         n0, d, got_data[d], got_lat[d], 16'(er[d]), el[d]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ov[d] !== 1'b1 || od[d] !== got_data[d] || bz[d] !== 1'b0) begin
                errors++;
                $display("FAIL done_hold n0=%0d dut%0d: out_valid=%b out_data=%h busy=%b, required 1 %h 0",
                         n0, d, ov[d], od[d], bz[d], got_data[d]);
            end
        end
    endtask

    task automatic release_job();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("release");
    endtask

    task automatic test_reset();
        srst = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        srst = 1'b0;
    endtask

    task automatic test_directed();
        run_job(16'd6);
        checks++;
        if (got_data[0] !== 16'd8 || got_lat[0] != (sc ? 7 : 9)) begin
            errors++;
            $display("FAIL n6: out_data=%0d latency=%0d, required 8 latency=%0d", got_data[0], got_lat[0], sc ? 7 : 9);
        end
        release_job();
        run_job(16'd27);
        checks++;
        if (got_data[0] !== 16'd111 || got_data[1] !== 16'hFFFF) begin
            errors++;
            $display("FAIL n27: out_data=%h/%h, required 006f/ffff", got_data[0], got_data[1]);
        end
        release_job();
        for (int k = 0; k < 2; k++) begin
            run_job(16'(k));
            checks++;
            if (got_data[0] !== 16'd0 || got_lat[0] != 1) begin
                errors++;
                $display("FAIL n%0d: out_data=%0d latency=%0d, required 0 latency=1", k, got_data[0], got_lat[0]);
            end
            release_job();
        end
        run_job(16'hFFFF);
        checks++;
        if (got_data[2] !== 16'hFFFF || got_lat[2] != 1) begin
            errors++;
            $display("FAIL w16_ovf: out_data=%h latency=%0d, required ffff latency=1", got_data[2], got_lat[2]);
        end
        release_job();
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_job(16'(i < 10 ? $urandom_range(2, 300) : $urandom_range(0, 65535)));
            release_job();
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        in_data = 16'd27;
        in_valid = 1'b1;
        @(posedge clk);
        for (int e = 1; e < 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            in_data = 16'($urandom_range(0, 65535));
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (ov[d] !== 1'b0 || bz[d] !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_run dut%0d edge %0d: out_valid=%b busy=%b, required 0 1", d, e, ov[d], bz[d]);
                end
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("abort");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("abort_stay");
        run_job(16'd7);
        checks++;
        if (got_data[0] !== 16'd16) begin
            errors++;
            $display("FAIL abort_rerun: out_data=%0d, required 16", got_data[0]);
        end
        release_job();
    endtask

    task automatic test_srst();
        @(negedge clk);
        in_data = 16'd27;
        in_valid = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        srst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("srst_run");
        srst = 1'b0;
        run_job(16'd7);
        checks++;
        if (got_data[0] !== 16'd16) begin
            errors++;
            $display("FAIL srst_run_rerun: out_data=%0d, required 16", got_data[0]);
        end
        @(negedge clk);
        srst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("srst_done");
        srst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        run_job(16'd7);
        checks++;
        if (got_data[0] !== 16'd16) begin
            errors++;
            $display("FAIL srst_done_rerun: out_data=%0d, required 16", got_data[0]);
        end
        release_job();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_srst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/kernel_collatz.md
Name: kernel_collatz

Overview:
- Per-thread compute kernel. One instance per thread slot, placed directly downstream of the 32-bit receive unpacker in the thread array.
- Accepts one 16-bit operand per job and iterates the Collatz map until the value reaches 1.
- Returns the 16-bit step count with a level valid flag, held until the job is released.
- Latency varies per operand. The top level asserts completion only after the last thread's out_valid is high.

Parameters:
- WIDTH, 32, internal datapath width of the iterated value; legal range 16..48.
- MAX_STEPS, 1000, step limit; legal range 1..16'hFFFE; results at or beyond this limit saturate.

Ports:
- clk  input  1  clock; all logic on posedge.
- srst  input  1  synchronous active-high reset.
- in_data  input  16  operand n0; sampled only on job start.
- in_valid  input  1  level job request; held high by the producer for the whole job.
- out_data  output  16  step count, or 16'hFFFF on overflow or limit.
- out_valid  output  1  result valid; level signal.
- busy  output  1  high while in RUN.

Behaviour:
- Reset and clock:
  - One clock: clk. Reset: srst is synchronous and active-high.
  - Reset forces state=IDLE, out_data=0, out_valid=0, busy=0, and clears n and steps. srst overrides every other input, including mid-job.
- Registers:
  - n: WIDTH bits.
  - steps: 16 bits.
  - State is one-hot: IDLE, RUN, DONE.
- IDLE:
  - out_valid=0.
  - On an edge with in_valid=1: n <= zero-extended in_data, steps <= 0, go to RUN.
- RUN: evaluated each edge in this priority order.
  1. in_valid=0: abort to IDLE. No result; out_valid stays 0.
  2. n<=1: out_data <= steps, out_valid <= 1, go to DONE.
  3. steps>=MAX_STEPS: out_data <= 16'hFFFF, go to DONE.
  4. n even: n <= n>>1, steps <= steps+1.
  5. n odd: compute 3n+1 in WIDTH+2 bits.
     - If the result does not fit in WIDTH bits: out_data <= 16'hFFFF, go to DONE.
     - Otherwise: n <= 3n+1, steps <= steps+1.
- DONE:
  - out_valid=1; out_data is held stable.
  - Stays in DONE while in_valid=1. When in_valid=0, goes to IDLE and out_valid returns to 0 on that edge.
  - A new job needs in_valid to be low for at least one edge.
- Latency:
  - With S true steps and no saturation, out_valid rises on edge S+1 after the capture edge.
  - Operands 0 and 1 give out_data=0, with out_valid on edge 1.
- Boundary rules:
  - The saturation value 16'hFFFF never collides with a real count, because MAX_STEPS<=16'hFFFE.
  - in_data is ignored outside the capture edge.
  - in_valid held high across DONE never restarts a job.

Optional Feature:
- Macro: COLLATZ_SHORTCUT_EN.
- Defined:
  - The odd step becomes n <= (3n+1)>>1 and steps <= steps+2.
  - The overflow check is still applied to the unshifted 3n+1 in WIDTH bits.
  - The MAX_STEPS check is unchanged.
  - out_data is bit-identical to the non-shortcut build for every operand; only latency drops.
- Undefined: one step per cycle exactly as described in Behaviour.

Test Plan:
- Reset then in_data=6, in_valid=1 held:
  - Plain build: out_valid rises 9 edges after capture, out_data=8.
  - COLLATZ_SHORTCUT_EN build: rises after 7 edges, out_data=8.
- in_data=27, default parameters: out_data=111 (decimal); with MAX_STEPS=100 the same input gives out_data=16'hFFFF.
- in_data=0 and in_data=1, each as a separate job: out_data=0, out_valid 1 edge after capture; busy pulses for 1 cycle.
- WIDTH=16, in_data=16'hFFFF: first step overflows (196606 > 65535) -> out_data=16'hFFFF, out_valid on edge 1.
- in_data=27, in_valid dropped on edge 20: kernel returns to IDLE, out_valid never asserts. Re-request with in_data=7 -> out_data=16.
- srst asserted mid-RUN, and separately while in DONE: next edge out_valid=0, out_data=0, busy=0. in_data=7 afterwards -> 16.
